// File: rtl/ghist_sram_pkg.sv
// Shared types and defaults for the ghist SRAM sequencer/arbiter.
package ghist_sram_pkg;

    localparam int unsigned GH_ADDR_W = 6;
    localparam int unsigned GH_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RMW_WR = 2'd2
    } gh_state_e;

    typedef enum logic {
        RR_RD = 1'b0,
        RR_WR = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/gc_rr_arb2.sv
// Two-way round-robin grant between the read and write requesters.
module gc_rr_arb2
    import ghist_sram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic rd_valid_i,
    input  logic wr_valid_i,
    output logic rd_gnt_o,
    output logic wr_gnt_o
);

    rr_sel_e ptr_q;
    rr_sel_e ptr_d;

    // A grant never looks at its own valid, only at the competitor's.
    always_comb begin
        rd_gnt_o = en_i & (~wr_valid_i | (ptr_q == RR_RD));
        wr_gnt_o = en_i & (~rd_valid_i | (ptr_q == RR_WR));
        ptr_d    = ptr_q;
        if (en_i && rd_valid_i && wr_valid_i) begin
            ptr_d = (ptr_q == RR_RD) ? RR_WR : RR_RD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= RR_RD;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ghist_sram_ctrl.sv
// Port sequencer for a single-port ghist SRAM macro: clear sweep, read/write
// arbitration and bit-masked writes turned into read-modify-write.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_CLEAR  | zero one word per cycle at clr_cnt; no grants
//  ST_IDLE   | arbitrate; reads, full writes, empty-mask writes complete here
//  ST_RMW_WR | write merged word for a partial-mask write; no grants
module ghist_sram_ctrl
    import ghist_sram_pkg::*;
#(
    parameter int unsigned ADDR_W         = GH_ADDR_W,
    parameter int unsigned DATA_W         = GH_DATA_W,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [DATA_W-1:0] wr_req_mask,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_A,
    output logic              sram_CSB,
    output logic              sram_WEB,
    output logic              sram_OEB,
    output logic [DATA_W-1:0] sram_I,
    input  logic [DATA_W-1:0] sram_O
);

    localparam int unsigned      DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
    localparam gh_state_e        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    gh_state_e         state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rd_resp_valid_q, rd_resp_valid_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [DATA_W-1:0] rmw_data_q, rmw_data_d;
    logic [DATA_W-1:0] rmw_mask_q, rmw_mask_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic              csb_d, web_d;

    logic arb_en;
    logic rd_fire, wr_fire;
    logic wr_full, wr_none;

    assign arb_en  = init_done_q & (state_q == ST_IDLE) & ~reset;
    assign rd_fire = rd_req_valid & rd_req_ready;
    assign wr_fire = wr_req_valid & wr_req_ready;
    assign wr_full = &wr_req_mask;
    assign wr_none = ~|wr_req_mask;

    gc_rr_arb2 u_arb (
        .clk_i      (clock),
        .rst_i      (reset),
        .en_i       (arb_en),
        .rd_valid_i (rd_req_valid),
        .wr_valid_i (wr_req_valid),
        .rd_gnt_o   (rd_req_ready),
        .wr_gnt_o   (wr_req_ready)
    );

    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        init_done_d     = init_done_q;
        rd_resp_valid_d = rd_fire;
        rmw_addr_d      = rmw_addr_q;
        rmw_data_d      = rmw_data_q;
        rmw_mask_d      = rmw_mask_q;
        a_d             = a_q;
        i_d             = i_q;
        csb_d           = 1'b1;
        web_d           = 1'b1;

        case (state_q)
            ST_CLEAR: begin
                csb_d     = 1'b0;
                web_d     = 1'b0;
                a_d       = clr_cnt_q[ADDR_W-1:0];
                i_d       = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_CNT) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (rd_fire) begin
                    csb_d = 1'b0;
                    a_d   = rd_req_addr;
                end else if (wr_fire && wr_full) begin
                    csb_d = 1'b0;
                    web_d = 1'b0;
                    a_d   = wr_req_addr;
                    i_d   = wr_req_data;
                end else if (wr_fire && !wr_none) begin
                    // Partial mask: fetch the old word now, merge next cycle.
                    csb_d      = 1'b0;
                    a_d        = wr_req_addr;
                    rmw_addr_d = wr_req_addr;
                    rmw_data_d = wr_req_data;
                    rmw_mask_d = wr_req_mask;
                    state_d    = ST_RMW_WR;
                end
            end
            ST_RMW_WR: begin
                csb_d   = 1'b0;
                web_d   = 1'b0;
                a_d     = rmw_addr_q;
                i_d     = (sram_O & ~rmw_mask_q) | (rmw_data_q & rmw_mask_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        // Keep the macro quiet while reset is held, whatever state we sit in.
        if (reset) begin
            csb_d = 1'b1;
            web_d = 1'b1;
            a_d   = '0;
            i_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RST_STATE;
            clr_cnt_q       <= '0;
            init_done_q     <= 1'b0;
            rd_resp_valid_q <= 1'b0;
            rmw_addr_q      <= '0;
            rmw_data_q      <= '0;
            rmw_mask_q      <= '0;
            a_q             <= '0;
            i_q             <= '0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            init_done_q     <= init_done_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rmw_addr_q      <= rmw_addr_d;
            rmw_data_q      <= rmw_data_d;
            rmw_mask_q      <= rmw_mask_d;
            a_q             <= a_d;
            i_q             <= i_d;
        end
    end

    assign sram_A        = a_d;
    assign sram_I        = i_d;
    assign sram_CSB      = csb_d;
    assign sram_WEB      = web_d;
    assign sram_OEB      = ~init_done_q;
    assign init_done     = init_done_q;
    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_resp_data  = sram_O;

endmodule

// File: tb/tb_ghist_sram_ctrl.sv
// Directed bench for ghist_sram_ctrl with a behavioural 64x128 macro model.
module tb_ghist_sram_ctrl;

    localparam logic [127:0] A5   = {16{8'hA5}};
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] RMWX = {{120{1'b1}}, 8'h00};
    localparam logic [127:0] W20  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         rd_req_valid = 1'b0;
    logic         rd_req_ready;
    logic [5:0]   rd_req_addr = '0;
    logic         rd_resp_valid;
    logic [127:0] rd_resp_data;
    logic         wr_req_valid = 1'b0;
    logic         wr_req_ready;
    logic [5:0]   wr_req_addr = '0;
    logic [127:0] wr_req_data = '0;
    logic [127:0] wr_req_mask = '0;
    logic         init_done;
    logic [5:0]   sram_A;
    logic         sram_CSB, sram_WEB, sram_OEB;
    logic [127:0] sram_I;
    logic [127:0] sram_O;

    logic [127:0] mem [64];

    int checks = 0;
    int errors = 0;
    int rise_k;

    always #5 clock = ~clock;

    ghist_sram_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_mask   (wr_req_mask),
        .init_done     (init_done),
        .sram_A        (sram_A),
        .sram_CSB      (sram_CSB),
        .sram_WEB      (sram_WEB),
        .sram_OEB      (sram_OEB),
        .sram_I        (sram_I),
        .sram_O        (sram_O)
    );

    // Macro model: CE tied to clock, data out one cycle after a read.
    always @(posedge clock) begin
        if (!sram_CSB) begin
            if (!sram_WEB) mem[sram_A] <= sram_I;
            else           sram_O      <= mem[sram_A];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rv, input logic [5:0] ra, input logic wv,
                       input logic [5:0] wa, input logic [127:0] wd, input logic [127:0] wm);
        @(negedge clock);
        rd_req_valid = rv;
        rd_req_addr  = ra;
        wr_req_valid = wv;
        wr_req_addr  = wa;
        wr_req_data  = wd;
        wr_req_mask  = wm;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= {$urandom, $urandom, $urandom, $urandom};

        // Reset values, with both requesters pushing.
        reset = 1'b1;
        repeat (3) cyc(1, 7, 1, 7, ONES, ONES);
        chk("rst_rd_rdy", rd_req_ready, 0);
        chk("rst_wr_rdy", wr_req_ready, 0);
        chk("rst_csb",    sram_CSB, 1);
        chk("rst_web",    sram_WEB, 1);
        chk("rst_oeb",    sram_OEB, 1);
        chk("rst_a",      sram_A, 0);
        chk("rst_i",      sram_I, 0);
        chk("rst_init",   init_done, 0);
        chk("rst_resp",   rd_resp_valid, 0);

        // Clear sweep: init_done exactly 64 cycles after reset falls.
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("swp_csb0", sram_CSB, 0);
        chk("swp_web0", sram_WEB, 0);
        chk("swp_a0",   sram_A, 0);
        rise_k = -1;
        for (int k = 1; k <= 100; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (k == 30) chk("swp_a30", sram_A, 30);
            if (init_done && rise_k < 0) begin
                rise_k = k;
                break;
            end
        end
        chk("swp_rise_cycle", rise_k, 64);
        chk("swp_oeb_low", sram_OEB, 0);

        // Back-to-back reads of cleared words.
        cyc(1, 0, 0, 0, 0, 0);
        chk("rd0_rdy", rd_req_ready, 1);
        chk("rd0_csb", sram_CSB, 0);
        chk("rd0_web", sram_WEB, 1);
        cyc(1, 17, 0, 0, 0, 0);
        chk("rd0_vld", rd_resp_valid, 1);
        chk("rd0_dat", rd_resp_data, 0);
        chk("rd17_a",  sram_A, 17);
        cyc(1, 63, 0, 0, 0, 0);
        chk("rd17_dat", rd_resp_data, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rd63_vld", rd_resp_valid, 1);
        chk("rd63_dat", rd_resp_data, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rd_idle_vld", rd_resp_valid, 0);
        chk("idle_csb",    sram_CSB, 1);

        // Full-mask write then immediate read of the same address.
        cyc(0, 0, 1, 5, A5, ONES);
        chk("wr5_rdy", wr_req_ready, 1);
        chk("wr5_csb", sram_CSB, 0);
        chk("wr5_web", sram_WEB, 0);
        chk("wr5_a",   sram_A, 5);
        chk("wr5_i",   sram_I, A5);
        cyc(1, 5, 0, 0, 0, 0);
        chk("rd5_rdy", rd_req_ready, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rd5_vld", rd_resp_valid, 1);
        chk("rd5_dat", rd_resp_data, A5);

        // RMW at addr 9, with a read accepted just before it.
        cyc(0, 0, 1, 9, ONES, ONES);
        cyc(1, 5, 0, 0, 0, 0);
        cyc(0, 0, 1, 9, 0, 128'hFF);
        chk("rmw_rdy",      wr_req_ready, 1);
        chk("rmw_rd_csb",   sram_CSB, 0);
        chk("rmw_rd_web",   sram_WEB, 1);
        chk("rmw_rd_a",     sram_A, 9);
        chk("rmw_prev_vld", rd_resp_valid, 1);
        chk("rmw_prev_dat", rd_resp_data, A5);
        cyc(1, 9, 1, 9, 0, ONES);
        chk("rmw_wr_rdrdy", rd_req_ready, 0);
        chk("rmw_wr_wrrdy", wr_req_ready, 0);
        chk("rmw_wr_vld",   rd_resp_valid, 0);
        chk("rmw_wr_csb",   sram_CSB, 0);
        chk("rmw_wr_web",   sram_WEB, 0);
        chk("rmw_wr_a",     sram_A, 9);
        chk("rmw_wr_i",     sram_I, RMWX);
        cyc(1, 9, 0, 0, 0, 0);
        chk("rmw_back_rdy", rd_req_ready, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rmw_rd_vld", rd_resp_valid, 1);
        chk("rmw_rd_dat", rd_resp_data, RMWX);

        // Contention: grants alternate starting with the read side.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 21, 1, 20, W20, ONES);
            chk("rr_rd", rd_req_ready, (i % 2) == 0);
            chk("rr_wr", wr_req_ready, (i % 2) == 1);
        end
        cyc(0, 0, 0, 0, 0, 0);

        // Empty-mask write consumes the grant without touching the macro.
        cyc(0, 0, 1, 3, 128'h1234, ONES);
        cyc(0, 0, 1, 3, ONES, 0);
        chk("m0_rdy", wr_req_ready, 1);
        chk("m0_csb", sram_CSB, 1);
        cyc(1, 3, 0, 0, 0, 0);
        chk("m0_rd_rdy", rd_req_ready, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("m0_dat", rd_resp_data, 128'h1234);

        // Reset in the middle of a sweep.
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (30) cyc(0, 0, 0, 0, 0, 0);
        chk("mid_a30", sram_A, 30);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("mid_rst_csb",  sram_CSB, 1);
        chk("mid_rst_a",    sram_A, 0);
        chk("mid_rst_init", init_done, 0);
        reset = 1'b0;
        #1;
        chk("mid_restart_csb", sram_CSB, 0);
        chk("mid_restart_a",   sram_A, 0);
        repeat (64) cyc(0, 0, 0, 0, 0, 0);
        chk("mid_done", init_done, 1);

        // Reset while in RMW_WR.
        cyc(0, 0, 1, 9, ONES, 128'hF0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rmwr_web", sram_WEB, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("rmwr_csb",  sram_CSB, 1);
        chk("rmwr_web1", sram_WEB, 1);
        chk("rmwr_i",    sram_I, 0);
        chk("rmwr_init", init_done, 0);
        chk("rmwr_oeb",  sram_OEB, 1);
        chk("rmwr_wrdy", wr_req_ready, 0);
        reset = 1'b0;
        #1;
        chk("rmwr_restart_a",   sram_A, 0);
        chk("rmwr_restart_csb", sram_CSB, 0);
        repeat (64) cyc(0, 0, 0, 0, 0, 0);
        chk("rmwr_done", init_done, 1);
        cyc(1, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rmwr_rd_vld", rd_resp_valid, 1);
        chk("rmwr_rd_dat", rd_resp_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
